// File: rtl/detector_jogada_pkg.sv
// -----------------------------------------------------------------------------
// detector_jogada_pkg
// Definitions shared by the play detector and the game's debug hex decoder.
//   estado_t                  : detector FSM states, as shown on db_estado
//   DEBOUNCE_CICLOS_PADRAO    : debounce interval for the 1 kHz board clock
// -----------------------------------------------------------------------------
package detector_jogada_pkg;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        FILTRA        = 2'd1,
        VALIDA        = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    // 20 cycles at 1 kHz = 20 ms of stable input.
    localparam int DEBOUNCE_CICLOS_PADRAO = 20;

endpackage

// File: rtl/detector_jogada_if.sv
// -----------------------------------------------------------------------------
// detector_jogada_if
// Signal bundle between the button conditioner and its neighbours.
//   botoes          : raw push-button bus, active-high, asynchronous
//   habilita        : 1 = a play may be accepted
//   jogada_feita    : single-cycle pulse per accepted press
//   jogada          : code of the last accepted press
//   jogada_multipla : pulse with jogada_feita when more than one button is set
//   db_estado       : current detector state, for debug display
// master = side that drives the buttons/enable; slave = the detector.
// -----------------------------------------------------------------------------
interface detector_jogada_if;

    logic [3:0] botoes;
    logic       habilita;
    logic       jogada_feita;
    logic [3:0] jogada;
    logic       jogada_multipla;
    logic [1:0] db_estado;

    modport master (
        output botoes,
        output habilita,
        input  jogada_feita,
        input  jogada,
        input  jogada_multipla,
        input  db_estado
    );

    modport slave (
        input  botoes,
        input  habilita,
        output jogada_feita,
        output jogada,
        output jogada_multipla,
        output db_estado
    );

endinterface

// File: rtl/detector_jogada_sincronizador_2ff.sv
// -----------------------------------------------------------------------------
// sincronizador_2ff
// Two-flop synchroniser for a bus of independent asynchronous bits.
//   clock   : destination clock
//   reset   : asynchronous reset, active-high (clears both stages)
//   i_dado  : asynchronous input bus
//   o_dado  : second-stage output, safe to use in the clock domain
// -----------------------------------------------------------------------------
module sincronizador_2ff #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] i_dado,
    output logic [LARGURA-1:0] o_dado
);

    logic [LARGURA-1:0] r_estagio1;
    logic [LARGURA-1:0] r_estagio2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estagio1 <= '0;
            r_estagio2 <= '0;
        end else begin
            r_estagio1 <= i_dado;
            r_estagio2 <= r_estagio1;
        end
    end

    assign o_dado = r_estagio2;

endmodule

// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
// Button conditioner for jogo_desafio_memoria: synchronises and debounces the
// raw button bus and produces one play per physical press.
//   clock : system clock (1 kHz on the board)
//   reset : asynchronous reset, active-high
//   bus   : detector_jogada_if.slave
//             botoes, habilita in; jogada_feita, jogada, jogada_multipla,
//             db_estado out
// Parameters
//   DEBOUNCE_CICLOS : stable cycles needed to accept a press or a release
//   CONT_BITS       : debounce counter width, 2**CONT_BITS > DEBOUNCE_CICLOS
// -----------------------------------------------------------------------------
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
    parameter int CONT_BITS       = 8
) (
    input logic               clock,
    input logic               reset,
    detector_jogada_if.slave  bus
);

    localparam logic [CONT_BITS-1:0] ULTIMO = CONT_BITS'(DEBOUNCE_CICLOS - 1);
    localparam logic [CONT_BITS-1:0] UM     = CONT_BITS'(1);

    logic [3:0]           w_sinc;
    logic                 w_multipla;
    estado_t              r_estado;
    logic [3:0]           r_candidato;
    logic [CONT_BITS-1:0] r_contador;
    logic [3:0]           r_jogada;
    logic                 r_jogada_feita;
    logic                 r_jogada_multipla;

    sincronizador_2ff #(.LARGURA(4)) u_sincronizador (
        .clock  (clock),
        .reset  (reset),
        .i_dado (bus.botoes),
        .o_dado (w_sinc)
    );

    // More than one bit set: clearing the lowest set bit leaves something.
    assign w_multipla = (r_candidato & (r_candidato - 4'd1)) != 4'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado          <= OCIOSO;
            r_candidato       <= '0;
            r_contador        <= '0;
            r_jogada          <= '0;
            r_jogada_feita    <= 1'b0;
            r_jogada_multipla <= 1'b0;
        end else begin
            r_jogada_feita    <= 1'b0;
            r_jogada_multipla <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (w_sinc != 4'd0) begin
                        r_candidato <= w_sinc;
                        r_contador  <= '0;
                        r_estado    <= FILTRA;
                    end
                end
                FILTRA: begin
                    if (w_sinc == 4'd0) begin
                        r_estado <= OCIOSO;
                    end else if (w_sinc != r_candidato) begin
                        // A bounce to another code restarts the filter.
                        r_candidato <= w_sinc;
                        r_contador  <= '0;
                    end else if (r_contador == ULTIMO) begin
                        // The play is registered on the edge that enters
                        // VALIDA, so the pulse and the new code are visible
                        // for exactly the one cycle spent in VALIDA.
                        r_estado <= VALIDA;
                        if (bus.habilita) begin
                            r_jogada          <= r_candidato;
                            r_jogada_feita    <= 1'b1;
                            r_jogada_multipla <= w_multipla;
                        end
                    end else begin
                        r_contador <= r_contador + UM;
                    end
                end
                VALIDA: begin
                    r_contador <= '0;
                    r_estado   <= ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    // Any button activity, including a different code, only
                    // restarts the release timer.
                    if (w_sinc != 4'd0) begin
                        r_contador <= '0;
                    end else if (r_contador == ULTIMO) begin
                        r_estado <= OCIOSO;
                    end else begin
                        r_contador <= r_contador + UM;
                    end
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign bus.jogada_feita    = r_jogada_feita;
    assign bus.jogada          = r_jogada;
    assign bus.jogada_multipla = r_jogada_multipla;
    assign bus.db_estado       = r_estado;

endmodule

// File: tb/tb_detector_jogada.sv
// -----------------------------------------------------------------------------
// tb_detector_jogada
// Directed scenarios plus a randomized phase for detector_jogada (D = 20).
// The reference model describes the behaviour in terms of run lengths of the
// synchronised button value: a press is accepted after D+1 identical nonzero
// samples while armed; after acceptance one sample is ignored and D
// consecutive zero samples re-arm the detector.
// -----------------------------------------------------------------------------
module tb_detector_jogada;
    import detector_jogada_pkg::*;

    localparam int D = 20;

    logic clock = 1'b0;
    logic reset;

    detector_jogada_if bus ();

    detector_jogada #(
        .DEBOUNCE_CICLOS (D),
        .CONT_BITS       (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int lat    = 0;

    // Reference model state
    logic [3:0] m_s1, m_s2, m_cur, m_jogada;
    int         m_run, m_zero;
    bit         m_armed, m_valida, m_pulse, m_mult;

    function automatic void model_clear();
        m_s1 = 4'd0; m_s2 = 4'd0; m_cur = 4'd0; m_jogada = 4'd0;
        m_run = 0; m_zero = 0;
        m_armed = 1'b1; m_valida = 1'b0; m_pulse = 1'b0; m_mult = 1'b0;
    endfunction

    function automatic void model_step(logic [3:0] b, logic hab);
        logic [3:0] x;
        x     = m_s2;
        m_s2  = m_s1;
        m_s1  = b;
        m_pulse = 1'b0;
        m_mult  = 1'b0;
        if (m_valida) begin
            m_valida = 1'b0;
            m_zero   = 0;
        end else if (m_armed) begin
            if (x == 4'd0) m_run = 0;
            else if (m_run > 0 && x == m_cur) m_run++;
            else begin m_cur = x; m_run = 1; end
            if (m_run == D + 1) begin
                m_armed  = 1'b0;
                m_valida = 1'b1;
                m_run    = 0;
                if (hab) begin
                    m_pulse  = 1'b1;
                    m_jogada = m_cur;
                    m_mult   = ($countones(m_cur) > 1);
                end
            end
        end else begin
            if (x != 4'd0) m_zero = 0;
            else m_zero++;
            if (m_zero == D) begin
                m_armed = 1'b1;
                m_zero  = 0;
                m_run   = 0;
            end
        end
    endfunction

    function automatic logic [1:0] model_estado();
        if (m_valida)     return 2'd2;
        if (!m_armed)     return 2'd3;
        if (m_run > 0)    return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: update model at the edge, compare at the falling edge.
    task automatic tick();
        @(posedge clock);
        if (reset) model_clear();
        else model_step(bus.botoes, bus.habilita);
        @(negedge clock);
        if (bus.jogada_feita === 1'b1) pulses++;
        chk("jogada_feita", {31'd0, bus.jogada_feita}, {31'd0, m_pulse});
        chk("jogada", {28'd0, bus.jogada}, {28'd0, m_jogada});
        chk("jogada_multipla", {31'd0, bus.jogada_multipla}, {31'd0, m_mult});
        chk("db_estado", {30'd0, bus.db_estado}, {30'd0, model_estado()});
    endtask

    task automatic hold(logic [3:0] v, int n);
        bus.botoes = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive v and count cycles until a pulse appears (bounded).
    task automatic press_measure(logic [3:0] v);
        bus.botoes = v;
        lat = 0;
        while (bus.jogada_feita !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic apply_reset(int n);
        reset = 1'b1;
        #1;
        chk("reset_async_feita", {31'd0, bus.jogada_feita}, 32'd0);
        chk("reset_async_jogada", {28'd0, bus.jogada}, 32'd0);
        chk("reset_async_estado", {30'd0, bus.db_estado}, 32'd0);
        for (int i = 0; i < n; i++) tick();
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.botoes   = 4'd0;
        bus.habilita = 1'b1;
        model_clear();
        tick();
        tick();
        chk("reset_jogada", {28'd0, bus.jogada}, 32'd0);
        chk("reset_estado", {30'd0, bus.db_estado}, 32'd0);
        reset = 1'b0;

        // 1: single press, latency and hold
        pulses = 0;
        press_measure(4'b0001);
        chk("t1_latency", lat, 32'd23);
        chk("t1_multipla", {31'd0, bus.jogada_multipla}, 32'd0);
        hold(4'b0001, 100 - lat);
        hold(4'b0000, 100);
        chk("t1_pulses", pulses, 32'd1);
        chk("t1_jogada", {28'd0, bus.jogada}, 32'h1);
        chk("t1_estado", {30'd0, bus.db_estado}, 32'd0);

        // 2: short glitch is rejected
        pulses = 0;
        hold(4'b0100, 5);
        chk("t2_estado_filtra", {30'd0, bus.db_estado}, 32'd1);
        hold(4'b0000, 30);
        chk("t2_pulses", pulses, 32'd0);
        chk("t2_jogada", {28'd0, bus.jogada}, 32'h1);
        chk("t2_estado", {30'd0, bus.db_estado}, 32'd0);

        // 3: bouncing press
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            hold(4'b0010, 2);
            hold(4'b0000, 2);
        end
        press_measure(4'b0010);
        chk("t3_latency", lat, 32'd23);
        hold(4'b0010, 100 - lat);
        hold(4'b0000, 100);
        chk("t3_pulses", pulses, 32'd1);
        chk("t3_jogada", {28'd0, bus.jogada}, 32'h2);

        // 4: all buttons pressed
        pulses = 0;
        press_measure(4'b1111);
        chk("t4_latency", lat, 32'd23);
        chk("t4_multipla", {31'd0, bus.jogada_multipla}, 32'd1);
        chk("t4_jogada", {28'd0, bus.jogada}, 32'hF);
        hold(4'b1111, 100 - lat);
        hold(4'b0000, 100);
        chk("t4_pulses", pulses, 32'd1);

        // 5: press while disabled is consumed
        pulses = 0;
        bus.habilita = 1'b0;
        hold(4'b1000, 100);
        chk("t5_pulses_dis", pulses, 32'd0);
        chk("t5_jogada", {28'd0, bus.jogada}, 32'hF);
        bus.habilita = 1'b1;
        hold(4'b1000, 50);
        chk("t5_pulses_held", pulses, 32'd0);
        chk("t5_estado", {30'd0, bus.db_estado}, 32'd3);
        hold(4'b0000, 100);

        // 6: reset during a press
        pulses = 0;
        hold(4'b0001, 10);
        apply_reset(3);
        press_measure(4'b0001);
        chk("t6_latency", lat, 32'd23);
        chk("t6_jogada1", {28'd0, bus.jogada}, 32'h1);
        hold(4'b0001, 100 - lat);
        hold(4'b0000, 100);
        press_measure(4'b0010);
        chk("t6_latency2", lat, 32'd23);
        chk("t6_jogada2", {28'd0, bus.jogada}, 32'h2);
        hold(4'b0010, 100 - lat);
        hold(4'b0000, 100);
        chk("t6_pulses", pulses, 32'd2);

        // Randomized phase against the reference model
        for (int k = 0; k < 150; k++) begin
            int r;
            logic [3:0] v;
            r = $urandom_range(0, 19);
            if (r < 2) bus.habilita = ~bus.habilita;
            if (r == 19) apply_reset($urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) v = 4'd0;
            else v = 4'($urandom_range(1, 15));
            hold(v, $urandom_range(1, 45));
        end
        hold(4'b0000, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
Input conditioning stage that sits directly upstream of jogo_desafio_memoria and feeds it conditioned button plays.
- Synchronises and debounces the raw 4-bit botoes bus.
- Emits exactly one single-cycle jogada_feita pulse per physical press.
- Presents a registered 4-bit jogada code that the game's comparator consumes.
- Blocks repeat pulses until the buttons have been released and have stayed released for a debounce interval.

Parameters:
- DEBOUNCE_CICLOS, 20, number of stable clock cycles required to accept a press or a release (20 ms at 1 kHz); legal range 2..255.
- CONT_BITS, 8, width of the debounce counter; must satisfy 2^CONT_BITS > DEBOUNCE_CICLOS.

Ports:
- clock  in  1  system clock (1 kHz in the board build).
- reset  in  1  asynchronous reset, active-high.
- botoes  in  4  raw push-button bus, active-high, asynchronous to clock.
- habilita  in  1  from control unit; 1 = a play may be accepted.
- jogada_feita  out  1  single-cycle pulse, one per accepted press.
- jogada  out  4  registered code of the last accepted press; held between presses.
- jogada_multipla  out  1  single-cycle pulse, coincident with jogada_feita, when more than one bit of jogada is set.
- db_estado  out  2  current FSM state, for hex-display debug.

Behaviour:
- Reset (async): all synchroniser flops, candidato, contador and jogada = 0; jogada_feita = 0; jogada_multipla = 0; FSM = OCIOSO.
- Synchroniser: 2-flop stage on all 4 bits; sinc denotes the second-stage output. The FSM sees only sinc.
- State encoding on db_estado: OCIOSO=0, FILTRA=1, VALIDA=2, ESPERA_SOLTAR=3.
- OCIOSO:
  - sinc == 0: stay.
  - sinc != 0: candidato <= sinc, contador <= 0, go to FILTRA.
- FILTRA:
  - sinc == 0: go to OCIOSO (glitch rejected, no output).
  - sinc != 0 and sinc != candidato: candidato <= sinc, contador <= 0, stay (bounce restarts the filter).
  - sinc == candidato and contador == DEBOUNCE_CICLOS-1: go to VALIDA.
  - Otherwise: contador++.
- VALIDA (exactly one cycle):
  - habilita == 1: jogada <= candidato; jogada_feita = 1; jogada_multipla = 1 if popcount(candidato) > 1.
  - habilita == 0: no pulse; jogada unchanged; the press is consumed.
  - Always go to ESPERA_SOLTAR with contador <= 0.
- ESPERA_SOLTAR:
  - sinc != 0: contador <= 0, stay.
  - sinc == 0 and contador == DEBOUNCE_CICLOS-1: go to OCIOSO.
  - Otherwise (sinc == 0): contador++.
- Pulse outputs are registered, asserted during the cycle that follows entry to VALIDA, and high for exactly 1 cycle.
- Latency: with botoes stable and nonzero from rising edge t0, FILTRA is entered at edge t0+3. jogada_feita and the new jogada are visible after edge t0+3+DEBOUNCE_CICLOS and until the next edge. With D=20 this is 23 cycles (23 ms).
- Minimum gap between two accepted presses: release must be stable for DEBOUNCE_CICLOS cycles plus 2 synchroniser cycles.
- Multi-button press: treated as one press with code = OR of the stable bits. It is forwarded so the game detects a wrong play, and it raises jogada_multipla.
- Change in which buttons are pressed while in ESPERA_SOLTAR: ignored. No second pulse until a full release.
- habilita changing mid-filter: sampled only in VALIDA.
- Reset mid-operation: immediate return to OCIOSO with all outputs 0. If a button is still held after reset deasserts, it is filtered afresh and accepted after the full latency.
- Counter never wraps, because it is bounded by DEBOUNCE_CICLOS-1 compares.

Decomposition:
- Shared package / include: state encodings (OCIOSO, FILTRA, VALIDA, ESPERA_SOLTAR) and the 1 kHz DEBOUNCE_CICLOS default. These are shared with the game's debug hex decoder.
- One natural sub-module: sincronizador_2ff, parameterised in width.
- Popcount > 1 is local combinational logic: (b & (b-1)) != 0.

Test Plan (D=20, 1 kHz clock):
1. Reset, habilita=1, botoes=0001 held 100 ms then 0 for 100 ms -> exactly one jogada_feita, 23 cycles after the press edge; jogada=0001 held afterwards; jogada_multipla=0; db_estado returns to 0.
2. Glitch: botoes=0100 for 5 ms then 0 -> no pulse; jogada unchanged; db_estado goes 1 then back to 0.
3. Bounce: 0010 toggled on/off every 2 ms for 10 ms, then held 100 ms -> one pulse, 20+3 cycles after the final stable edge; jogada=0010.
4. botoes=1111 held 100 ms -> one pulse; jogada=1111; jogada_multipla=1 in the same cycle.
5. habilita=0, botoes=1000 held 100 ms -> no pulse and jogada unchanged. Then habilita=1 with the button still held -> still no pulse until a release and a new press.
6. Reset asserted 10 ms into a 0001 press, released with the button still held -> outputs 0 during reset; one pulse 23 cycles after reset release; then after release and 0010 held 100 ms, a second pulse with jogada=0010.
